// File: rtl/irq_prio_vic_pkg.sv
// Shared constants and types for the prioritised vectored interrupt controller.
package irq_pkg;

    localparam int N_SRC_MAX = 8;
    localparam int PRIO_W    = 2;
    localparam int ID_W      = 3;
    localparam int STK_DEPTH = 4;

    // Byte offsets inside the 0x8F00 MMIO window.
    localparam logic [3:0] VIC_PEND   = 4'h0;
    localparam logic [3:0] VIC_MASK   = 4'h2;
    localparam logic [3:0] VIC_PRIO   = 4'h4;
    localparam logic [3:0] VIC_VBASE  = 4'h6;
    localparam logic [3:0] VIC_ACTIVE = 4'h8;
    localparam logic [3:0] VIC_STATE  = 4'hA;

    // Source ids as wired in periph_bus.
    localparam int IRQ_ID_GPIO   = 0;
    localparam int IRQ_ID_UART   = 1;
    localparam int IRQ_ID_TIMER  = 2;
    localparam int IRQ_ID_SPI    = 3;
    localparam int IRQ_ID_I2C    = 4;
    localparam int IRQ_ID_PWM    = 5;
    localparam int IRQ_ID_DMA    = 6;
    localparam int IRQ_ID_WDT    = 7;

    // One in-service stack entry: which source and the priority it was taken at.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [PRIO_W-1:0] prio;
    } stk_entry_t;

    // Handler address for a source id, 16-bit wraparound.
    function automatic logic [15:0] vic_vector(input logic [15:0] vbase,
                                               input logic [ID_W-1:0] id,
                                               input int stride_log2);
        return vbase + (16'(id) << stride_log2);
    endfunction

endpackage

// File: rtl/irq_prio_vic_if.sv
// MMIO register-window bus between periph_bus and the interrupt controller.
interface irq_prio_vic_if;
    logic        i_sel;
    logic        i_we;
    logic        i_re;
    logic [3:0]  i_addr;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;

    modport master (output i_sel, i_we, i_re, i_addr, i_wdata, input o_rdata);
    modport slave  (input i_sel, i_we, i_re, i_addr, i_wdata, output o_rdata);
endinterface

// File: rtl/irq_prio_vic_pick.sv
// Combinational winner select: highest priority candidate, ties to lowest id.
module irq_prio_pick
    import irq_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0]        i_cand,
    input  logic [PRIO_W*N_SRC-1:0] i_prio,
    output logic                    o_valid,
    output logic [ID_W-1:0]         o_id,
    output logic [PRIO_W-1:0]       o_prio
);

    logic              best_valid;
    logic [ID_W-1:0]   best_id;
    logic [PRIO_W-1:0] best_prio;

    // Scan upward and replace only on strictly higher priority, so ties keep the lower index.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        best_valid = 1'b0;
        best_id    = '0;
        best_prio  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (i_cand[k] && (!best_valid || (i_prio[PRIO_W*k +: PRIO_W] > best_prio))) begin
                best_valid = 1'b1;
                best_id    = ID_W'(k);
                best_prio  = i_prio[PRIO_W*k +: PRIO_W];
            end
        end
    end

    assign o_valid = best_valid;
    assign o_id    = best_id;
    assign o_prio  = best_prio;

endmodule

// File: rtl/irq_prio_vic.sv
// Nesting vectored interrupt controller: pending/mask/priority registers, in-service stack, take sequencing.
module irq_prio_vic
    import irq_pkg::*;
#(
    parameter int          N_SRC        = 8,
    parameter logic [15:0] VBASE_RST    = 16'h0060,
    parameter int          VSTRIDE_LOG2 = 4,
    parameter int          HOLDOFF      = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    irq_prio_vic_if.slave    bus,
    input  logic [N_SRC-1:0] i_irq_src,
    input  logic             i_in_irq,
    input  logic             i_int_en,
    input  logic             i_irq_ret,
    output logic             o_irq_take,
    output logic [15:0]      o_irq_vector
);

    logic [N_SRC-1:0]        src_hist_q, src_hist_d;
    logic [N_SRC-1:0]        pend_q, pend_d;
    logic [N_SRC-1:0]        mask_q, mask_d;
    logic [PRIO_W*N_SRC-1:0] prio_q, prio_d;
    logic [15:0]             vbase_q, vbase_d;
    logic [N_SRC-1:0]        active_q, active_d;
    stk_entry_t              stk_q [STK_DEPTH];
    stk_entry_t              stk_d [STK_DEPTH];
    logic [2:0]              depth_q, depth_d;
    logic [7:0]              holdoff_q, holdoff_d;
    logic                    take_q, take_d;
    logic [15:0]             vector_q, vector_d;

    logic [3:0]        reg_off;
    logic              pop;
    logic [2:0]        depth_pp;
    logic [N_SRC-1:0]  active_pp;
    stk_entry_t        top_cur, top_pp;
    logic [N_SRC-1:0]  cand;
    logic              win_valid;
    logic [ID_W-1:0]   win_id;
    logic [PRIO_W-1:0] win_prio;
    logic              issue;

    // Address bit 0 is masked off so odd offsets alias the even register.
    assign reg_off = bus.i_addr & 4'hE;

    // Apply a return first so this cycle's arbitration sees the post-pop stack.
    always_comb begin
        top_cur   = (depth_q != 3'd0) ? stk_q[2'(depth_q - 3'd1)] : '0;
        pop       = i_irq_ret && (depth_q != 3'd0);
        depth_pp  = pop ? (depth_q - 3'd1) : depth_q;
        active_pp = active_q;
        if (pop) active_pp[top_cur.id] = 1'b0;
        top_pp    = (depth_pp != 3'd0) ? stk_q[2'(depth_pp - 3'd1)] : '0;
        cand      = pend_q & mask_q & ~active_pp;
    end

    irq_prio_pick #(.N_SRC(N_SRC)) u_pick (
        .i_cand  (cand),
        .i_prio  (prio_q),
        .o_valid (win_valid),
        .o_id    (win_id),
        .o_prio  (win_prio)
    );

    // Next-state for pending, stack, take pulse, holdoff and the MMIO-writable registers.
    always_comb begin
        logic [N_SRC-1:0] w1c;
        logic [N_SRC-1:0] take_clr;
        src_hist_d = i_irq_src;
        mask_d     = mask_q;
        prio_d     = prio_q;
        vbase_d    = vbase_q;
        stk_d      = stk_q;
        depth_d    = depth_pp;
        active_d   = active_pp;
        vector_d   = vector_q;
        holdoff_d  = (holdoff_q != 8'd0) ? (holdoff_q - 8'd1) : 8'd0;
        w1c        = '0;
        take_clr   = '0;

        issue = i_int_en && (holdoff_q == 8'd0) && win_valid
             && ((depth_pp == 3'd0) || (win_prio > top_pp.prio))
             && (!i_in_irq || (depth_pp != 3'd0))
             && (depth_pp < 3'(STK_DEPTH));
        take_d = issue;

        if (issue) begin
            stk_d[depth_pp[1:0]] = '{id: win_id, prio: win_prio};
            depth_d              = depth_pp + 3'd1;
            active_d[win_id]     = 1'b1;
            take_clr[win_id]     = 1'b1;
            vector_d             = vic_vector(vbase_q, win_id, VSTRIDE_LOG2);
            holdoff_d            = 8'(HOLDOFF);
        end

        if (bus.i_sel && bus.i_we) begin
            case (reg_off)
                VIC_PEND:  w1c     = bus.i_wdata[N_SRC-1:0];
                VIC_MASK:  mask_d  = bus.i_wdata[N_SRC-1:0];
                VIC_PRIO:  prio_d  = bus.i_wdata[PRIO_W*N_SRC-1:0];
                VIC_VBASE: vbase_d = bus.i_wdata;
                default:   ;
            endcase
        end

        // A fresh edge wins over both W1C and the take clear.
        pend_d = (pend_q & ~w1c & ~take_clr) | (i_irq_src & ~src_hist_q);
    end

    // Register state; the stack array is small and is reset so STATE never reads stale ids.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            src_hist_q <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            prio_q     <= '0;
            vbase_q    <= VBASE_RST;
            active_q   <= '0;
            for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
            depth_q    <= '0;
            holdoff_q  <= '0;
            take_q     <= 1'b0;
            vector_q   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
            src_hist_q <= src_hist_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            prio_q     <= prio_d;
            vbase_q    <= vbase_d;
            active_q   <= active_d;
            stk_q      <= stk_d;
            depth_q    <= depth_d;
            holdoff_q  <= holdoff_d;
            take_q     <= take_d;
            vector_q   <= vector_d;
        end
    end

    // Combinational register read, zero unless a read is strobed.
    always_comb begin
        bus.o_rdata = '0;
        if (bus.i_sel && bus.i_re) begin
            case (reg_off)
                VIC_PEND:   bus.o_rdata = 16'(pend_q);
                VIC_MASK:   bus.o_rdata = 16'(mask_q);
                VIC_PRIO:   bus.o_rdata = 16'(prio_q);
                VIC_VBASE:  bus.o_rdata = vbase_q;
                VIC_ACTIVE: bus.o_rdata = 16'(active_q);
                VIC_STATE:  bus.o_rdata = {6'd0, top_cur.prio, 1'b0, top_cur.id, 1'b0, depth_q};
                default:    bus.o_rdata = '0;
            endcase
        end
    end

    assign o_irq_take   = take_q;
    assign o_irq_vector = vector_q;

endmodule

// File: tb/tb_irq_prio_vic.sv
// Self-checking bench: random and directed stimulus, behavioural model feeding a take scoreboard.
module tb_irq_prio_vic;
    import irq_pkg::*;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  src = '0;
    logic        in_irq = 1'b0, int_en = 1'b0, irq_ret = 1'b0;
    logic        take;
    logic [15:0] vec;

    irq_prio_vic_if bus ();

    irq_prio_vic #(.N_SRC(8), .VBASE_RST(16'h0060), .VSTRIDE_LOG2(4), .HOLDOFF(HOLD)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bus),
        .i_irq_src    (src),
        .i_in_irq     (in_irq),
        .i_int_en     (int_en),
        .i_irq_ret    (irq_ret),
        .o_irq_take   (take),
        .o_irq_vector (vec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [15:0] vec; int cyc; } exp_t;
    exp_t        exp_q[$];
    bit          m_pend [8];
    bit          m_hist [8];
    logic [7:0]  m_mask;
    int          m_prio [8];
    logic [15:0] m_vbase;
    int          stk_id[$];
    int          stk_pr[$];
    int          m_hold;
    int          cyc = 0;

    function automatic bit in_service(input int k);
        foreach (stk_id[i]) if (stk_id[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin m_pend[k] = 0; m_hist[k] = 0; m_prio[k] = 0; end
        m_mask = '0; m_vbase = 16'h0060; m_hold = 0;
        stk_id.delete(); stk_pr.delete(); exp_q.delete();
    endtask

    task automatic model_step();
        int best;
        bit tk, w1c, rise;
        best = -1;
        cyc++;
        if (irq_ret && stk_id.size() > 0) begin
            void'(stk_id.pop_back());
            void'(stk_pr.pop_back());
        end
        for (int k = 0; k < 8; k++)
            if (m_pend[k] && m_mask[k] && !in_service(k))
                if (best < 0 || m_prio[k] > m_prio[best]) best = k;
        tk = int_en && m_hold == 0 && best >= 0
          && (stk_id.size() == 0 || m_prio[best] > stk_pr[stk_id.size()-1])
          && (!in_irq || stk_id.size() > 0) && stk_id.size() < 4;
        for (int k = 0; k < 8; k++) begin
            rise = src[k] && !m_hist[k];
            w1c  = bus.i_sel && bus.i_we && bus.i_addr[3:1] == 3'd0 && bus.i_wdata[k];
            m_pend[k] = rise || (m_pend[k] && !w1c && !(tk && best == k));
            m_hist[k] = src[k];
        end
        if (tk) begin
            stk_id.push_back(best);
            stk_pr.push_back(m_prio[best]);
            exp_q.push_back('{vec: 16'(m_vbase + 16'(best * 16)), cyc: cyc});
            m_hold = HOLD;
        end else if (m_hold > 0) begin
            m_hold--;
        end
        if (bus.i_sel && bus.i_we) begin
            case (bus.i_addr[3:1])
                3'd1: m_mask = bus.i_wdata[7:0];
                3'd2: for (int k = 0; k < 8; k++) m_prio[k] = int'(bus.i_wdata[2*k +: 2]);
                3'd3: m_vbase = bus.i_wdata;
                default: ;
            endcase
        end
    endtask

    function automatic logic [15:0] exp_reg(input logic [3:0] a);
        logic [15:0] r;
        int n;
        r = '0;
        n = stk_id.size();
        case (a[3:1])
            3'd0: for (int k = 0; k < 8; k++) r[k] = m_pend[k];
            3'd1: r = {8'd0, m_mask};
            3'd2: for (int k = 0; k < 8; k++) r[2*k +: 2] = 2'(m_prio[k]);
            3'd3: r = m_vbase;
            3'd4: foreach (stk_id[i]) r[stk_id[i]] = 1'b1;
            3'd5: if (n > 0) r = 16'(n + stk_id[n-1] * 16 + stk_pr[n-1] * 256);
            default: r = '0;
        endcase
        return r;
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- scoreboard monitor ----------------
    int          take_cnt = 0;
    logic [15:0] last_vec = '0;

    always @(negedge clk) begin
        if (rst_n && take) begin
            take_cnt++;
            last_vec = vec;
            if (exp_q.size() == 0) begin
                check("take_unexpected", 32'(vec), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("take_vector", 32'(vec), 32'(e.vec));
                check("take_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mmio_wr(input logic [3:0] a, input logic [15:0] d);
        bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = a; bus.i_wdata = d;
        @(negedge clk);
        bus.i_sel = 1'b0; bus.i_we = 1'b0;
    endtask

    task automatic rd_const(input string name, input logic [3:0] a, input logic [15:0] exp);
        bus.i_sel = 1'b1; bus.i_re = 1'b1; bus.i_addr = a;
        #1 check(name, 32'(bus.o_rdata), 32'(exp));
        bus.i_sel = 1'b0; bus.i_re = 1'b0;
    endtask

    task automatic rd_model(input string name, input logic [3:0] a);
        rd_const(name, a, exp_reg(a));
    endtask

    task automatic pulse_src(input logic [7:0] m);
        src = src | m;
        @(negedge clk);
        src = src & ~m;
    endtask

    task automatic do_ret();
        irq_ret = 1'b1;
        @(negedge clk);
        irq_ret = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int c0;
        bus.i_sel = 1'b0; bus.i_we = 1'b0; bus.i_re = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;

        // reset state
        #12;
        check("rst_take", 32'(take), 32'd0);
        check("rst_vector", 32'(vec), 32'd0);
        rd_const("rst_vbase", VIC_VBASE, 16'h0060);
        rd_const("rst_mask", VIC_MASK, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        int_en = 1'b1;
        tick(2);

        // single source
        mmio_wr(VIC_MASK, 16'h0010);
        mmio_wr(VIC_PRIO, 16'h0000);
        c0 = take_cnt;
        pulse_src(8'h10);
        tick(4);
        check("single_count", 32'(take_cnt - c0), 32'd1);
        check("single_vec", 32'(last_vec), 32'h00A0);
        rd_const("single_pend", VIC_PEND, 16'h0000);
        rd_const("single_active", VIC_ACTIVE, 16'h0010);
        rd_const("single_state", VIC_STATE, 16'h0041);
        do_ret();
        tick(2);
        rd_const("single_active_ret", VIC_ACTIVE, 16'h0000);
        rd_const("single_state_ret", VIC_STATE, 16'h0000);

        // tie break and pending until return
        mmio_wr(VIC_MASK, 16'h00FF);
        c0 = take_cnt;
        pulse_src(8'h24);
        tick(4);
        check("tie_vec", 32'(last_vec), 32'h0080);
        rd_const("tie_pend", VIC_PEND, 16'h0020);
        tick(6);
        check("tie_hold_count", 32'(take_cnt - c0), 32'd1);
        do_ret();
        tick(4);
        check("tie_second_vec", 32'(last_vec), 32'h00B0);
        do_ret();
        tick(3);

        // preemption
        mmio_wr(VIC_PRIO, 16'h3004);
        pulse_src(8'h02);
        tick(4);
        check("pre_first_vec", 32'(last_vec), 32'h0070);
        in_irq = 1'b1;
        pulse_src(8'h40);
        tick(4);
        check("pre_nest_vec", 32'(last_vec), 32'h00C0);
        rd_const("pre_state", VIC_STATE, 16'h0362);
        c0 = take_cnt;
        pulse_src(8'h02);
        tick(4);
        check("pre_blocked_active", 32'(take_cnt - c0), 32'd0);
        do_ret();
        tick(4);
        check("pre_blocked_one_ret", 32'(take_cnt - c0), 32'd0);
        in_irq = 1'b0;
        do_ret();
        tick(3);
        check("pre_after_rets", 32'(take_cnt - c0), 32'd1);
        check("pre_after_vec", 32'(last_vec), 32'h0070);
        do_ret();
        tick(3);

        // global enable and mask gating
        int_en = 1'b0;
        c0 = take_cnt;
        pulse_src(8'h08);
        tick(4);
        check("gate_en_off", 32'(take_cnt - c0), 32'd0);
        int_en = 1'b1;
        tick(2);
        check("gate_en_on", 32'(take_cnt - c0), 32'd1);
        check("gate_vec", 32'(last_vec), 32'h0090);
        do_ret();
        tick(3);
        mmio_wr(VIC_MASK, 16'h00F7);
        c0 = take_cnt;
        pulse_src(8'h08);
        tick(4);
        check("gate_masked", 32'(take_cnt - c0), 32'd0);
        rd_const("gate_masked_pend", VIC_PEND, 16'h0008);
        mmio_wr(VIC_PEND, 16'h0008);

        // edge versus W1C race
        mmio_wr(VIC_MASK, 16'h0000);
        src[0] = 1'b1;
        mmio_wr(VIC_PEND, 16'h0001);
        tick(2);
        rd_const("race_pend_set", VIC_PEND, 16'h0001);
        mmio_wr(VIC_PEND, 16'h0001);
        tick(3);
        rd_const("race_held_high", VIC_PEND, 16'h0000);
        src[0] = 1'b0;
        tick(2);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            src     = src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            irq_ret = ($urandom_range(0, 7) == 0);
            in_irq  = ($urandom_range(0, 3) == 0);
            int_en  = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 15);
            bus.i_sel = 1'b0; bus.i_we = 1'b0; bus.i_re = 1'b0;
            case (r)
                0: begin bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = VIC_MASK;  bus.i_wdata = 16'($urandom); end
                1: begin bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = VIC_PRIO;  bus.i_wdata = 16'($urandom); end
                2: begin bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = VIC_PEND;  bus.i_wdata = 16'($urandom); end
                3: begin bus.i_sel = 1'b1; bus.i_we = 1'b1; bus.i_addr = VIC_VBASE; bus.i_wdata = 16'($urandom); end
                4, 5: rd_model("rand_read", 4'($urandom_range(0, 15)));
                default: ;
            endcase
            @(negedge clk);
        end
        bus.i_sel = 1'b0; bus.i_we = 1'b0;
        src = '0; irq_ret = 1'b0; in_irq = 1'b0; int_en = 1'b0;
        tick(2);
        check("rand_drain", 32'(exp_q.size()), 32'd0);

        // async reset while two handlers are nested
        repeat (4) do_ret();
        mmio_wr(VIC_PEND, 16'h00FF);
        mmio_wr(VIC_PRIO, 16'h3004);
        mmio_wr(VIC_MASK, 16'h0042);
        mmio_wr(VIC_VBASE, 16'h1200);
        tick(2);
        int_en = 1'b1;
        pulse_src(8'h02);
        tick(4);
        in_irq = 1'b1;
        pulse_src(8'h40);
        tick(4);
        check("ar_vec", 32'(last_vec), 32'h1260);
        rd_const("ar_state_pre", VIC_STATE, 16'h0362);
        #2 rst_n = 1'b0;
        #1 check("ar_take", 32'(take), 32'd0);
        check("ar_vector", 32'(vec), 32'd0);
        rd_const("ar_vbase", VIC_VBASE, 16'h0060);
        rd_const("ar_state", VIC_STATE, 16'h0000);
        rd_const("ar_active", VIC_ACTIVE, 16'h0000);
        rd_const("ar_prio", VIC_PRIO, 16'h0000);
        @(negedge clk);
        in_irq = 1'b0;
        rst_n = 1'b1;
        tick(3);
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_prio_vic.md
Name: irq_prio_vic

Overview:
- Priority-based, nesting vectored interrupt controller. It arbitrates up to 8 peripheral IRQ sources (GPIO, UART, timer, I2C, ...) for the CPU's single interrupt entry.
- Sits inside periph_bus at MMIO window 0x8F00. It replaces the flat mask-only VIC and adds per-source priority plus preemption of lower-priority handlers.
- Produces a one-cycle take pulse and a 16-bit handler vector.

Parameters:
- N_SRC, 8, number of IRQ sources (1..8).
- VBASE_RST, 16'h0060, reset value of the vector base register.
- VSTRIDE_LOG2, 4, vector = VBASE + (id << VSTRIDE_LOG2); with the defaults, I2C (id 4) yields vector 0x00A0.
- HOLDOFF, 2, cycles after a take during which no new take may issue.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_sel  in  1  MMIO select for this window.
- i_we  in  1  write strobe, valid with i_sel.
- i_re  in  1  read strobe, valid with i_sel.
- i_addr  in  4  byte offset within the window; bit0 ignored.
- i_wdata  in  16  write data.
- o_rdata  out  16  read data; combinational from i_addr, 0 when !(i_sel&i_re).
- i_irq_src  in  N_SRC  raw source lines; rising edge requests.
- i_in_irq  in  1  CPU is executing a handler.
- i_int_en  in  1  CPU global interrupt enable.
- i_irq_ret  in  1  one-cycle pulse: CPU executed return-from-interrupt.
- o_irq_take  out  1  one-cycle pulse: CPU must vector now.
- o_irq_vector  out  16  handler address; valid while o_irq_take=1.

Behaviour:
- Register map:
  - 0x0 PEND: R, W1C.
  - 0x2 MASK: RW, 1 = enabled.
  - 0x4 PRIO: RW, 2 bits per source, src k at [2k+1:2k].
  - 0x6 VBASE: RW.
  - 0x8 ACTIVE: R, one-hot-per-source set of in-service sources.
  - 0xA STATE: R, [2:0] stack depth, [6:4] top id, [9:8] top priority.
  - Unused offsets read 0; writes to them are ignored.
- Reset (async, i_rst_n=0):
  - PEND=0, MASK=0, PRIO=0, VBASE=VBASE_RST, ACTIVE=0, stack empty, holdoff counter=0.
  - o_irq_take=0, o_irq_vector=0.
  - Edge-detect history is loaded with 0, so a source held high at reset release requests once.
- Pending:
  - PEND[k] sets on a registered rising edge of i_irq_src[k].
  - Set beats a same-cycle W1C and beats a same-cycle take-clear.
- Arbitration (combinational, registered output):
  - Candidates = PEND & MASK & ~ACTIVE.
  - Winner = highest PRIO; ties go to the lowest index.
  - Preemption allowed iff stack empty, or winner prio > top prio (strictly).
  - Issue iff i_int_en & holdoff==0 & candidate exists & preemption allowed & (!i_in_irq | stack non-empty).
  - i_in_irq with an empty stack means a software trap is in progress; no take is issued in that case.
- Take (registered):
  - Next cycle: o_irq_take=1 for exactly one cycle.
  - o_irq_vector = VBASE + (id<<VSTRIDE_LOG2), 16-bit wraparound.
  - PEND[id] cleared, ACTIVE[id] set, {id,prio} pushed, holdoff loaded with HOLDOFF.
  - o_irq_vector holds its last value after the take pulse.
- Stack:
  - Depth 4 (one entry per priority level).
  - Strict-greater preemption guarantees depth never exceeds 4; the push is still guarded by !full.
- Return:
  - i_irq_ret pops the top entry and clears ACTIVE[top id].
  - Ret on an empty stack is ignored.
  - Ret and take decision in the same cycle: the pop is applied first, and arbitration for that cycle uses the post-pop top.
- MMIO:
  - Write to MASK/PRIO takes effect on the next cycle's arbitration.
  - Masking an ACTIVE source does not pop it.
- Holdoff: decrements to 0 each cycle; a new take is blocked while it is nonzero.

Decomposition:
- Shared package irq_pkg:
  - register offsets (VIC_PEND, VIC_MASK, VIC_PRIO, VIC_VBASE, VIC_ACTIVE, VIC_STATE);
  - source id constants (IRQ_ID_I2C=4, etc.);
  - N_SRC_MAX=8, PRIO_W=2.
- Sub-module irq_prio_pick: purely combinational winner select (candidates, PRIO) -> {valid, id, prio}. The top module holds the registers, stack and sequencing.

Test Plan:
- Single source: MASK=0x0010, PRIO=0; pulse src4 -> exactly one o_irq_take, vector 0x00A0; PEND[4]=0, ACTIVE=0x0010, STATE depth 1; after i_irq_ret, ACTIVE=0 and depth 0.
- Tie/priority:
  - MASK=0x00FF, PRIO all 0; pulse src2 and src5 together -> first take vector 0x0080 (id 2).
  - Source 5 stays pending until ret; then second take has vector 0x00B0.
- Preemption:
  - PRIO[1]=1, PRIO[6]=3; take src1, assert i_in_irq, pulse src6 -> take vector 0x00C0, depth 2, STATE top prio 3.
  - Pulse src1 again -> no take until both rets complete.
- Gating:
  - i_int_en=0 with src3 pending -> no take; raise i_int_en -> take within 2 cycles.
  - MASK bit cleared -> PEND still sets, no take.
- W1C/edge race: pulse src0 in the same cycle as a PEND W1C of bit0 -> PEND[0] remains 1. Holding src0 high produces no further requests.
- Async reset mid-handler:
  - Assert i_rst_n=0 with depth 2 -> all registers at reset values immediately, without a clock.
  - o_irq_take=0, VBASE=0x0060.
